// File: rtl/alu_booth_mul_32.sv
// Sequential signed multiplier, radix-4 Booth recoding, one multiplier bit-pair per clock.
// start/busy/done handshake; the 2*WIDTH-bit product is presented on hi/lo when done pulses.
module alu_booth_mul_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [4:0]       count,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // two guard bits let the accumulator hold +/-2M of the most-negative operand
  localparam int         AW    = WIDTH + 2;
  localparam logic [4:0] ITERS = 5'(WIDTH / 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [AW-1:0]    a_r, a_s;
  logic [AW-1:0]    m_r, m_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             qm1_r, qm1_s;
  logic             busy_s, done_s;
  logic [4:0]       count_s;
  logic [WIDTH-1:0] hi_s, lo_s;
  logic [AW-1:0]    addend_s, sum_s;

  function automatic logic [AW-1:0] booth_sel(input logic [2:0] bits, input logic [AW-1:0] m);
    logic [AW-1:0] one;
    logic [AW-1:0] m2;
    one = {{(AW-1){1'b0}}, 1'b1};
    m2  = {m[AW-2:0], 1'b0};
    case (bits)
      3'b000, 3'b111: booth_sel = {AW{1'b0}};
      3'b001, 3'b010: booth_sel = m;
      3'b011:         booth_sel = m2;
      3'b100:         booth_sel = ~m2 + one;
      3'b101, 3'b110: booth_sel = ~m + one;
      default:        booth_sel = {AW{1'b0}};
    endcase
  endfunction

  // next-state and datapath: capture on accepted start, one Booth step per RUN cycle
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    m_s      = m_r;
    q_s      = q_r;
    qm1_s    = qm1_r;
    busy_s   = busy;
    done_s   = done;
    count_s  = count;
    hi_s     = hi;
    lo_s     = lo;
    addend_s = booth_sel({q_r[1:0], qm1_r}, m_r);
    sum_s    = a_r + addend_s;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          m_s     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
          q_s     = multiplier;
          qm1_s   = 1'b0;
          a_s     = {AW{1'b0}};
          count_s = ITERS;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          state_s = RUN;
        end else begin
          busy_s  = 1'b0;
          done_s  = 1'b0;
          state_s = IDLE;
        end
      end
      RUN: begin
        a_s     = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
        q_s     = {sum_s[1:0], q_r[WIDTH-1:2]};
        qm1_s   = q_r[1];
        count_s = count - 5'd1;
        if (count == 5'd1) begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
          hi_s    = a_s[WIDTH-1:0];
          lo_s    = q_s;
          state_s = DONE;
        end else begin
          busy_s  = 1'b1;
          done_s  = 1'b0;
          state_s = RUN;
        end
      end
      default: begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // state and output registers; reset clears everything and aborts any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= {AW{1'b0}};
      m_r     <= {AW{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      qm1_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= 5'd0;
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      m_r     <= m_s;
      q_r     <= q_s;
      qm1_r   <= qm1_s;
      busy    <= busy_s;
      done    <= done_s;
      count   <= count_s;
      hi      <= hi_s;
      lo      <= lo_s;
    end
  end

endmodule

// File: tb/tb_alu_booth_mul_32.sv
// Directed-vector and random bench for alu_booth_mul_32: latency, handshake, corner
// operands, ignored mid-run start, asynchronous abort.
module tb_alu_booth_mul_32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          idle_first;
  } vec_t;

  vec_t vecs[8];

  alu_booth_mul_32 #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .count(count),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full operation; disturb_at>0 pulses start with junk operands before that RUN edge.
  task automatic do_mul(input logic [31:0] m, input logic [31:0] q, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit idle_first, input int disturb_at);
    if (idle_first) begin
      start = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy", busy, 64'd0);
      chk("idle_done", done, 64'd0);
      chk("idle_hold_lo", lo, prev_lo);
    end
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = m ^ q ^ 32'h5A5A_A5A5;
    chk("accept_busy", busy, 64'd1);
    chk("accept_done", done, 64'd0);
    chk("accept_count", count, 64'd16);
    for (int i = 1; i <= 16; i++) begin
      if (disturb_at != 0 && i == disturb_at) begin
        start        = 1'b1;
        multiplicand = 32'h0000_0064;
        multiplier   = 32'h0000_00C8;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("run_count", count, 64'(16 - i));
      if (i < 16) begin
        chk("run_busy", busy, 64'd1);
        chk("run_done", done, 64'd0);
        chk("run_hold_hi", hi, prev_hi);
        chk("run_hold_lo", lo, prev_lo);
      end else begin
        chk("done_busy", busy, 64'd0);
        chk("done_pulse", done, 64'd1);
        chk("prod_hi", hi, ehi);
        chk("prod_lo", lo, elo);
      end
    end
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    reset = 1'b1;
    start = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;

    vecs[0] = '{32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[2] = '{32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000, 1'b1};
    vecs[7] = '{32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1};

    #12;
    chk("rst_busy", busy, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_count", count, 64'd0);
    chk("rst_hi", hi, 64'd0);
    chk("rst_lo", lo, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 8; v++)
      do_mul(vecs[v].m, vecs[v].q, vecs[v].exp_hi, vecs[v].exp_lo, vecs[v].idle_first, 0);

    // mid-run start ignored, then back-to-back start in the DONE cycle
    do_mul(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b1, 5);
    do_mul(32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 0);

    // asynchronous abort partway through 9*9
    start        = 1'b0;
    @(posedge clk); #1;
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 64'd0);
    chk("abort_done", done, 64'd0);
    chk("abort_count", count, 64'd0);
    chk("abort_hi", hi, 64'd0);
    chk("abort_lo", lo, 64'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("post_abort_done", done, 64'd0);
      chk("post_abort_busy", busy, 64'd0);
    end
    do_mul(32'd9, 32'd9, 32'h0000_0000, 32'h0000_0051, 1'b0, 0);

    for (int r = 0; r < 1000; r++) begin
      logic [31:0] rm;
      logic [31:0] rq;
      longint      p;
      rm = $urandom;
      rq = $urandom;
      if (r % 7 == 0) rm = {rm[31], 31'd0};
      if (r % 11 == 0) rq = {rq[31], {31{~rq[31]}}};
      p = longint'($signed(rm)) * longint'($signed(rq));
      do_mul(rm, rq, p[63:32], p[31:0], (r % 2) == 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
